// File: rtl/mtsp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mtsp_mem_arbiter
//
// Shares one memory target port between NUM_REQ MTSP cores. Each core's memory
// stage fires single-cycle requests that cannot be back-pressured. A request is
// caught in a per-core holding slot, and STALL is raised for that core while
// the slot is occupied. Occupied slots are granted round-robin into a
// registered VALID/READY master port. Read returns arrive in issue order. They
// are routed back to the issuing core, together with the destination GPR
// index, through a small tag FIFO.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   REQ_nEN           per-core request strobe (active-low, one cycle)
//   REQ_WRITE         per-core write flag (1=write, 0=read)
//   REQ_ADDR          per-core word address, core i at [i*ADDR_W +: ADDR_W]
//   REQ_SRC           per-core GPR index, packed the same way
//   REQ_DATA_0/1      per-core source operands, packed the same way
//   STALL             per-core stall (registered): slot occupied
//   M_VALID/M_READY   master request handshake
//   M_WRITE, M_ADDR, M_SRC, M_DATA_0, M_DATA_1   master request fields
//   R_VALID, R_DATA   in-order read data return
//   RD_VALID          registered one-hot read-return strobe per core
//   RD_SRC, RD_DATA   GPR index and data of the returned read
//   ERR               sticky: [0] request into full slot, [1] R_VALID w/o tag
// -----------------------------------------------------------------------------
module mtsp_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned GPR_W     = 6,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          REQ_nEN,
  input  logic [NUM_REQ-1:0]          REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*GPR_W-1:0]    REQ_SRC,
  input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA_0,
  input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA_1,
  output logic [NUM_REQ-1:0]          STALL,
  output logic                        M_VALID,
  input  logic                        M_READY,
  output logic                        M_WRITE,
  output logic [ADDR_W-1:0]           M_ADDR,
  output logic [GPR_W-1:0]            M_SRC,
  output logic [DATA_W-1:0]           M_DATA_0,
  output logic [DATA_W-1:0]           M_DATA_1,
  input  logic                        R_VALID,
  input  logic [DATA_W-1:0]           R_DATA,
  output logic [NUM_REQ-1:0]          RD_VALID,
  output logic [GPR_W-1:0]            RD_SRC,
  output logic [DATA_W-1:0]           RD_DATA,
  output logic [1:0]                  ERR
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  // Occupancy limit expressed in the occupancy counter width.
  localparam logic [TAG_AW+1:0] TAG_FULL = (TAG_AW + 2)'(TAG_DEPTH);

  // ---------------------------------------------------------------------------
  // Holding slots
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] r_slot_vld;
  logic [NUM_REQ-1:0] r_slot_wr;
  logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
  logic [GPR_W-1:0]   r_slot_src  [NUM_REQ];
  logic [DATA_W-1:0]  r_slot_d0   [NUM_REQ];
  logic [DATA_W-1:0]  r_slot_d1   [NUM_REQ];

  // ---------------------------------------------------------------------------
  // Master output register
  // ---------------------------------------------------------------------------
  logic               r_m_valid;
  logic               r_m_write;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [GPR_W-1:0]   r_m_src;
  logic [DATA_W-1:0]  r_m_d0;
  logic [DATA_W-1:0]  r_m_d1;
  logic [IDX_W-1:0]   r_m_idx;

  // Round-robin pointer
  logic [IDX_W-1:0]   r_ptr;

  // ---------------------------------------------------------------------------
  // Outstanding-read tag FIFO (pointers carry an extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]   r_tag_idx [TAG_DEPTH];
  logic [GPR_W-1:0]   r_tag_src [TAG_DEPTH];
  logic [TAG_AW:0]    r_wp;
  logic [TAG_AW:0]    r_rp;

  // Read return and error registers
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [GPR_W-1:0]   r_rd_src;
  logic [DATA_W-1:0]  r_rd_data;
  logic [1:0]         r_err;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [TAG_AW:0]    w_fifo_cnt;
  logic               w_fifo_empty;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_load_en;
  logic               w_out_rd;
  logic [TAG_AW+1:0]  w_occupied;
  logic               w_tag_ok;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_capture;
  logic               w_grant_vld;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_load;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [IDX_W-1:0]   w_head_idx;
  logic [GPR_W-1:0]   w_head_src;
  logic [NUM_REQ-1:0] w_rd_onehot;

  assign w_fifo_cnt   = r_wp - r_rp;
  assign w_fifo_empty = (r_wp == r_rp);
  assign w_accept     = r_m_valid & M_READY;
  assign w_push       = w_accept & ~r_m_write;
  assign w_pop        = R_VALID & ~w_fifo_empty;
  assign w_load_en    = ~r_m_valid | M_READY;

  // A read sitting in the output register already owns a tag: whether it is
  // accepted this cycle or not, it will occupy a FIFO entry. A new read may
  // only be loaded if that leaves room for it as well.
  assign w_out_rd   = r_m_valid & ~r_m_write;
  assign w_occupied = {1'b0, w_fifo_cnt} + {{(TAG_AW + 1){1'b0}}, w_out_rd};
  assign w_tag_ok   = (w_occupied < TAG_FULL);

  assign w_elig    = r_slot_vld & (r_slot_wr | {NUM_REQ{w_tag_ok}});
  assign w_req     = ~REQ_nEN;
  assign w_capture = w_req & ~r_slot_vld;

  // First eligible slot at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((k + 32'(r_ptr)) % NUM_REQ);
      if (!w_grant_vld && w_elig[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_load    = w_load_en & w_grant_vld;
  assign w_ptr_nxt = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : w_grant_idx + 1'b1;

  assign w_head_idx = r_tag_idx[r_rp[TAG_AW-1:0]];
  assign w_head_src = r_tag_src[r_rp[TAG_AW-1:0]];

  always_comb begin
    w_rd_onehot             = '0;
    w_rd_onehot[w_head_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Slot capture / release
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slot_vld <= '0;
      r_slot_wr  <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_slot_addr[i] <= '0;
        r_slot_src[i]  <= '0;
        r_slot_d0[i]   <= '0;
        r_slot_d1[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        // Capture and grant of one slot never coincide: capture needs the
        // slot empty, grant needs it full.
        if (w_capture[i]) begin
          r_slot_vld[i]  <= 1'b1;
          r_slot_wr[i]   <= REQ_WRITE[i];
          r_slot_addr[i] <= REQ_ADDR[i*ADDR_W +: ADDR_W];
          r_slot_src[i]  <= REQ_SRC[i*GPR_W +: GPR_W];
          r_slot_d0[i]   <= REQ_DATA_0[i*DATA_W +: DATA_W];
          r_slot_d1[i]   <= REQ_DATA_1[i*DATA_W +: DATA_W];
        end else if (w_load && (w_grant_idx == IDX_W'(i))) begin
          r_slot_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m_valid <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_src   <= '0;
      r_m_d0    <= '0;
      r_m_d1    <= '0;
      r_m_idx   <= '0;
      r_ptr     <= '0;
    end else if (w_load_en) begin
      r_m_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_m_write <= r_slot_wr[w_grant_idx];
        r_m_addr  <= r_slot_addr[w_grant_idx];
        r_m_src   <= r_slot_src[w_grant_idx];
        r_m_d0    <= r_slot_d0[w_grant_idx];
        r_m_d1    <= r_slot_d1[w_grant_idx];
        r_m_idx   <= w_grant_idx;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_tag_idx[r_wp[TAG_AW-1:0]] <= r_m_idx;
      r_tag_src[r_wp[TAG_AW-1:0]] <= r_m_src;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return routing and sticky errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_valid <= '0;
      r_rd_src   <= '0;
      r_rd_data  <= '0;
      r_err      <= '0;
    end else begin
      r_rd_valid <= w_pop ? w_rd_onehot : '0;
      if (w_pop) begin
        r_rd_src  <= w_head_src;
        r_rd_data <= R_DATA;
      end
      r_err[0] <= r_err[0] | (|(w_req & r_slot_vld));
      r_err[1] <= r_err[1] | (R_VALID & w_fifo_empty);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign STALL    = r_slot_vld;
  assign M_VALID  = r_m_valid;
  assign M_WRITE  = r_m_write;
  assign M_ADDR   = r_m_addr;
  assign M_SRC    = r_m_src;
  assign M_DATA_0 = r_m_d0;
  assign M_DATA_1 = r_m_d1;
  assign RD_VALID = r_rd_valid;
  assign RD_SRC   = r_rd_src;
  assign RD_DATA  = r_rd_data;
  assign ERR      = r_err;

endmodule

// File: tb/tb_mtsp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mtsp_mem_arbiter
//
// Directed bench for mtsp_mem_arbiter. Every request the bench expects to see
// on the master port is queued when the request is driven. Every read return
// it expects is queued when R_VALID is driven. A monitor on the falling edge
// pops and compares both queues as the DUT produces them. The main sequence
// also checks cycle-exact flags directly.
// -----------------------------------------------------------------------------
module tb_mtsp_mem_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned GW = 6;
  localparam int unsigned DW = 128;
  localparam int unsigned TD = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NR-1:0]    REQ_nEN;
  logic [NR-1:0]    REQ_WRITE;
  logic [NR*AW-1:0] REQ_ADDR;
  logic [NR*GW-1:0] REQ_SRC;
  logic [NR*DW-1:0] REQ_DATA_0;
  logic [NR*DW-1:0] REQ_DATA_1;
  logic [NR-1:0]    STALL;
  logic             M_VALID;
  logic             M_READY;
  logic             M_WRITE;
  logic [AW-1:0]    M_ADDR;
  logic [GW-1:0]    M_SRC;
  logic [DW-1:0]    M_DATA_0;
  logic [DW-1:0]    M_DATA_1;
  logic             R_VALID;
  logic [DW-1:0]    R_DATA;
  logic [NR-1:0]    RD_VALID;
  logic [GW-1:0]    RD_SRC;
  logic [DW-1:0]    RD_DATA;
  logic [1:0]       ERR;

  mtsp_mem_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .GPR_W    (GW),
    .DATA_W   (DW),
    .TAG_DEPTH(TD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_nEN   (REQ_nEN),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_SRC   (REQ_SRC),
    .REQ_DATA_0(REQ_DATA_0),
    .REQ_DATA_1(REQ_DATA_1),
    .STALL     (STALL),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_WRITE   (M_WRITE),
    .M_ADDR    (M_ADDR),
    .M_SRC     (M_SRC),
    .M_DATA_0  (M_DATA_0),
    .M_DATA_1  (M_DATA_1),
    .R_VALID   (R_VALID),
    .R_DATA    (R_DATA),
    .RD_VALID  (RD_VALID),
    .RD_SRC    (RD_SRC),
    .RD_DATA   (RD_DATA),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [GW-1:0] src;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } mtx_t;

  typedef struct {
    logic [NR-1:0] vec;
    logic [GW-1:0] src;
    logic [DW-1:0] data;
  } rtx_t;

  mtx_t mq[$];
  rtx_t rq[$];
  mtx_t m_exp;
  rtx_t r_exp;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkd(input logic [AW-1:0] a);
    return {4{a, 16'hC0DE}};
  endfunction

  // Drive one request strobe for core c; optionally queue it as expected.
  task automatic set_req(input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [GW-1:0] s, input bit expect_it);
    mtx_t e;
    REQ_nEN[c]                = 1'b0;
    REQ_WRITE[c]              = wr;
    REQ_ADDR[c*AW +: AW]      = a;
    REQ_SRC[c*GW +: GW]       = s;
    REQ_DATA_0[c*DW +: DW]    = mkd(a);
    REQ_DATA_1[c*DW +: DW]    = ~mkd(a);
    if (expect_it) begin
      e.wr   = wr;
      e.addr = a;
      e.src  = s;
      e.d0   = mkd(a);
      e.d1   = ~mkd(a);
      mq.push_back(e);
    end
  endtask

  task automatic ret_read(input int c, input logic [GW-1:0] s, input logic [DW-1:0] d);
    rtx_t r;
    R_VALID  = 1'b1;
    R_DATA   = d;
    r.vec    = '0;
    r.vec[c] = 1'b1;
    r.src    = s;
    r.data   = d;
    rq.push_back(r);
  endtask

  // One clock: inputs change 1 time unit after the rising edge; strobes are
  // single-cycle so they are withdrawn here.
  task automatic step();
    @(posedge CLK);
    #1;
    REQ_nEN = '1;
    R_VALID = 1'b0;
  endtask

  task automatic wait_mq(input int budget);
    int n = 0;
    while (mq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("m_queue_drained", mq.size(), 0);
  endtask

  task automatic wait_rq(input int budget);
    int n = 0;
    while (rq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("rd_queue_drained", rq.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (M_VALID === 1'b1 && M_READY === 1'b1) begin
      chk("m_expected", (mq.size() != 0), 1'b1);
      if (mq.size() != 0) begin
        m_exp = mq.pop_front();
        chk("m_write", M_WRITE,  m_exp.wr);
        chk("m_addr",  M_ADDR,   m_exp.addr);
        chk("m_src",   M_SRC,    m_exp.src);
        chk("m_data0", M_DATA_0, m_exp.d0);
        chk("m_data1", M_DATA_1, m_exp.d1);
      end
    end
    if ((|RD_VALID) === 1'b1) begin
      chk("rd_expected", (rq.size() != 0), 1'b1);
      if (rq.size() != 0) begin
        r_exp = rq.pop_front();
        chk("rd_valid", RD_VALID, r_exp.vec);
        chk("rd_src",   RD_SRC,   r_exp.src);
        chk("rd_data",  RD_DATA,  r_exp.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    REQ_nEN    = '1;
    REQ_WRITE  = '0;
    REQ_ADDR   = '0;
    REQ_SRC    = '0;
    REQ_DATA_0 = '0;
    REQ_DATA_1 = '0;
    M_READY    = 1'b0;
    R_VALID    = 1'b0;
    R_DATA     = '0;
    RST        = 1'b1;
    repeat (3) step();

    // ---- reset state ----
    chk("rst_stall",    STALL,    0);
    chk("rst_m_valid",  M_VALID,  0);
    chk("rst_m_addr",   M_ADDR,   0);
    chk("rst_m_data0",  M_DATA_0, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_rd_src",   RD_SRC,   0);
    chk("rst_rd_data",  RD_DATA,  0);
    chk("rst_err",      ERR,      0);
    RST = 1'b0;
    step();

    // ---- round robin from pointer 0 ----
    M_READY = 1'b1;
    for (int c = 0; c < 4; c++) set_req(c, 1'b1, 16'h0100 + 16'(c), 6'(c + 1), 1'b1);
    step();
    chk("rr_stall_all", STALL,   4'hF);
    chk("rr_no_valid",  M_VALID, 0);
    step();
    chk("rr_first_valid", M_VALID, 1);
    chk("rr_first_addr",  M_ADDR,  16'h0100);
    set_req(0, 1'b1, 16'h0200, 6'd9, 1'b1);
    step();
    chk("rr_second_addr", M_ADDR, 16'h0101);
    wait_mq(20);

    // ---- single write from core 2 (pointer now 1) ----
    set_req(2, 1'b1, 16'h0040, 6'd5, 1'b1);
    step();
    chk("sw_stall_t1", STALL[2], 1);
    chk("sw_valid_t1", M_VALID,  0);
    step();
    chk("sw_valid_t2", M_VALID, 1);
    chk("sw_addr_t2",  M_ADDR,  16'h0040);
    chk("sw_write_t2", M_WRITE, 1);
    step();
    chk("sw_stall_t3", STALL[2], 0);
    chk("sw_valid_t3", M_VALID,  0);
    wait_mq(5);

    // ---- back-pressure: pointer 3, core 0 wins, core 1 waits ----
    M_READY = 1'b0;
    set_req(0, 1'b1, 16'h0300, 6'd20, 1'b1);
    set_req(1, 1'b1, 16'h0301, 6'd21, 1'b1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  M_VALID,  1);
      chk("bp_addr",   M_ADDR,   16'h0300);
      chk("bp_src",    M_SRC,    6'd20);
      chk("bp_data0",  M_DATA_0, mkd(16'h0300));
      chk("bp_stall1", STALL[1], 1);
      step();
    end
    M_READY = 1'b1;
    step();
    chk("bp_first_ready_accept", mq.size(), 1);
    chk("bp_next_addr",          M_ADDR,    16'h0301);
    wait_mq(10);

    // ---- tag FIFO full: five reads from core 3 ----
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (STALL[3] !== 1'b0 && n < 10) begin
        step();
        n++;
      end
      chk("tf_slot_free", STALL[3], 0);
      set_req(3, 1'b0, 16'h0400 + 16'(k), 6'(10 + k), 1'b1);
      step();
    end
    repeat (6) step();
    chk("tf_held_valid", M_VALID,   0);
    chk("tf_held_queue", mq.size(), 1);
    chk("tf_held_stall", STALL[3],  1);
    ret_read(3, 6'd10, 128'hA5);
    step();
    chk("tf_rd_valid", RD_VALID, 4'b1000);
    chk("tf_rd_data",  RD_DATA,  128'hA5);
    step();
    chk("tf_fifth_valid", M_VALID, 1);
    chk("tf_fifth_addr",  M_ADDR,  16'h0404);
    wait_mq(5);
    for (int k = 1; k < 5; k++) begin
      ret_read(3, 6'(10 + k), 128'hB0 + 128'(k));
      step();
    end
    wait_rq(5);

    // ---- errors: core 0 strobes twice while stalled ----
    chk("err_clean", ERR, 0);
    M_READY = 1'b0;
    set_req(1, 1'b1, 16'h0500, 6'd30, 1'b1);
    step();
    set_req(0, 1'b1, 16'h0501, 6'd31, 1'b1);
    step();
    chk("err_stalled", STALL[0], 1);
    set_req(0, 1'b1, 16'h0666, 6'd7, 1'b0);
    step();
    chk("err_full_slot_1", ERR, 2'b01);
    set_req(0, 1'b1, 16'h0667, 6'd8, 1'b0);
    step();
    chk("err_full_slot_2", ERR, 2'b01);
    M_READY = 1'b1;
    wait_mq(10);
    R_VALID = 1'b1;
    R_DATA  = 128'hDEAD;
    step();
    chk("err_no_tag",    ERR,      2'b11);
    chk("err_no_rd",     RD_VALID, 0);
    step();
    chk("err_sticky",    ERR,      2'b11);

    // ---- reset mid-operation ----
    set_req(1, 1'b0, 16'h0600, 6'd40, 1'b1);
    set_req(2, 1'b0, 16'h0601, 6'd41, 1'b1);
    wait_mq(10);
    M_READY = 1'b0;
    set_req(0, 1'b1, 16'h0700, 6'd1, 1'b0);
    set_req(1, 1'b1, 16'h0701, 6'd2, 1'b0);
    set_req(2, 1'b1, 16'h0702, 6'd3, 1'b0);
    step();
    step();
    chk("mr_pre_stall", STALL,   4'b0110);
    chk("mr_pre_valid", M_VALID, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mr_stall",    STALL,    0);
    chk("mr_m_valid",  M_VALID,  0);
    chk("mr_m_write",  M_WRITE,  0);
    chk("mr_m_addr",   M_ADDR,   0);
    chk("mr_m_src",    M_SRC,    0);
    chk("mr_m_data0",  M_DATA_0, 0);
    chk("mr_m_data1",  M_DATA_1, 0);
    chk("mr_rd_valid", RD_VALID, 0);
    chk("mr_rd_src",   RD_SRC,   0);
    chk("mr_rd_data",  RD_DATA,  0);
    chk("mr_err",      ERR,      0);
    // Pointer back at 0: core 0 must beat core 2.
    M_READY = 1'b1;
    set_req(0, 1'b1, 16'h0801, 6'd51, 1'b1);
    set_req(2, 1'b1, 16'h0800, 6'd50, 1'b1);
    wait_mq(10);
    // Outstanding tags were discarded: a return now has no tag.
    R_VALID = 1'b1;
    R_DATA  = 128'h1234;
    step();
    chk("mr_fifo_empty", ERR,      2'b10);
    chk("mr_no_rd",      RD_VALID, 0);
    repeat (3) step();
    chk("final_rd_queue", rq.size(), 0);
    chk("final_m_queue",  mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mtsp_mem_arbiter.md
Name: mtsp_mem_arbiter

Overview:
Shares one memory target port (e.g. scratch or stream memory) between NUM_REQ MTSP cores. Each core's memory stage issues single-cycle, non-back-pressured requests. The arbiter catches each request in a per-core holding slot and signals STALL to that core while the slot is occupied. It grants slots round-robin onto a registered VALID/READY master port and routes in-order read returns back to the issuing core with its destination GPR index.

Parameters:
NUM_REQ, 4, number of requesting cores (2..8)
ADDR_W, 16, memory word address width
GPR_W, 6, GPR index width carried with each request
DATA_W, 128, width of each source data operand
TAG_DEPTH, 4, outstanding-read tag FIFO depth (power of 2)

Ports:
CLK  in  1  main clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
REQ_nEN  in  NUM_REQ  per-core request strobe, active-low, one cycle per request
REQ_WRITE  in  NUM_REQ  per-core write flag (1=write, 0=read)
REQ_ADDR  in  NUM_REQ*ADDR_W  per-core address, packed, core i at [i*ADDR_W +: ADDR_W]
REQ_SRC  in  NUM_REQ*GPR_W  per-core GPR index, packed
REQ_DATA_0  in  NUM_REQ*DATA_W  per-core operand 0, packed
REQ_DATA_1  in  NUM_REQ*DATA_W  per-core operand 1, packed
STALL  out  NUM_REQ  registered; core i must not issue while STALL[i]=1
M_VALID  out  1  master request valid
M_READY  in  1  memory accepts request
M_WRITE  out  1  request write flag
M_ADDR  out  ADDR_W  request address
M_SRC  out  GPR_W  request GPR index
M_DATA_0  out  DATA_W  operand 0
M_DATA_1  out  DATA_W  operand 1
R_VALID  in  1  read data return strobe, in issue order
R_DATA  in  DATA_W  read data
RD_VALID  out  NUM_REQ  registered one-hot read-return strobe per core
RD_SRC  out  GPR_W  GPR index of the returned read
RD_DATA  out  DATA_W  returned read data
ERR  out  2  sticky: [0] request while slot full, [1] R_VALID with no tag

Behaviour:
- Reset: all slots empty. STALL=0, M_VALID=0, M_* fields=0, RD_VALID=0, RD_SRC=0, RD_DATA=0, ERR=0. Round-robin pointer=0 and tag FIFO empty. Reset mid-transaction discards all pending and outstanding state.
- Slot capture: if REQ_nEN[i]=0 and slot i is empty, slot i loads WRITE/ADDR/SRC/DATA at the edge. STALL[i]=1 from the next cycle until the slot is granted.
- Request into a full slot: dropped, ERR[0] set. Slot contents are unchanged.
- Output register: loads when M_VALID=0, or when M_VALID&M_READY in the same cycle (back-to-back allowed). While M_VALID=1 and M_READY=0, all M_* fields hold stable.
- Arbitration: among eligible slots, pick the first index >= pointer, wrapping modulo NUM_REQ. On load, pointer <= winner+1 (wrapping), the winning slot is cleared and STALL drops the following cycle.
- Read throttling: a read slot is eligible only if the tag FIFO will not be full. Count the loaded-but-unaccepted output read as an occupied tag. Write slots are always eligible.
- Latency: request at cycle t gives slot valid at t+1 and M_VALID at t+2 at the earliest. A slot request and a grant of the same slot in one cycle are impossible, since the slot is empty.
- Tag FIFO: on M_VALID&M_READY&~M_WRITE, push {winner index, M_SRC}. On R_VALID, pop.
  - Push and pop in the same cycle: count unchanged.
  - R_VALID while FIFO empty: ignored, ERR[1] set.
- Read return: on R_VALID with a tag, next cycle RD_VALID[tag idx]=1 for one cycle, with RD_SRC=tag SRC and RD_DATA=R_DATA. Otherwise RD_VALID=0; RD_SRC/RD_DATA hold their last values.
- Width rules: pointer and tag index are clog2(NUM_REQ) bits. FIFO pointers are log2(TAG_DEPTH) bits plus a wrap bit for full/empty.
- ERR clears only on RST.

Test Plan:
- Single write: core 2 issues WRITE=1, ADDR=16'h0040, SRC=5, M_READY=1 at t -> STALL[2]=1 at t+1. M_VALID=1 with ADDR=16'h0040 at t+2. STALL[2]=0 at t+3.
- Round robin: all 4 cores request in the same cycle, M_READY=1 -> grants in order 0,1,2,3 on consecutive cycles. A new core 0 request then wins after core 3.
- Back-pressure: M_READY=0 for 5 cycles with core 1 pending -> M_* fields are stable for all 5 cycles. STALL[1] stays 1, and acceptance occurs on the first READY cycle.
- Tag full: 5 reads from core 3 with no R_VALID, TAG_DEPTH=4 -> 4 accepted and the 5th is held (M_VALID=0). One R_VALID with R_DATA=128'hA5 -> RD_VALID=4'b1000, RD_DATA=128'hA5. The 5th read issues next.
- Errors: core 0 strobes twice while stalled -> ERR=2'b01, original request delivered unchanged. R_VALID with empty FIFO -> ERR=2'b11.
- Reset mid-op: RST for 1 cycle with 2 slots full and 2 tags outstanding -> next cycle all outputs zero, FIFO empty, pointer=0.
